// File: rtl/ctrl_cmd_arbiter_pkg.sv
// ctrl_arb_pkg: shared definitions for the command arbiter slice.
//   - 3-bit state encodings and the FSM state enum built from them
//   - RW and Mode field values as seen by the RW control FSM
package ctrl_arb_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_DONE = 3'd2;
  localparam logic [2:0] ST_COMPLETE  = 3'd3;
  localparam logic [2:0] ST_ABORT     = 3'd4;

  typedef enum logic [2:0] {
    StIdle     = ST_IDLE,
    StIssue    = ST_ISSUE,
    StWaitDone = ST_WAIT_DONE,
    StComplete = ST_COMPLETE,
    StAbort    = ST_ABORT
  } arbState_t;

  localparam logic RW_READ     = 1'b0;
  localparam logic RW_WRITE    = 1'b1;
  localparam logic MODE_SERIAL = 1'b0;
  localparam logic MODE_MEM    = 1'b1;

endpackage

// File: rtl/ctrl_cmd_arbiter_if.sv
// ctrl_cmd_if: command port between the arbiter and the RW control FSM.
//   ValidCmd  arbiter -> controller  command valid
//   RW        arbiter -> controller  0=read, 1=write
//   Mode      arbiter -> controller  1=memory path, 0=serial-only
//   Active    arbiter -> controller  global enable pass-through
//   Busy      controller -> arbiter  operation in progress
interface ctrl_cmd_if;
  logic ValidCmd;
  logic RW;
  logic Mode;
  logic Active;
  logic Busy;

  modport master (output ValidCmd, output RW, output Mode, output Active, input Busy);
  modport slave  (input ValidCmd, input RW, input Mode, input Active, output Busy);
endinterface

// File: rtl/ctrl_cmd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req  in   NUM_REQ  request vector
//   ptr  in   IW       highest-priority index
//   any  out  1        at least one request set
//   idx  out  IW       first set request at or after ptr, wrapping
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               any,
  output logic [IW-1:0]      idx
);

  logic [IW:0] cand;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (req[cand[IW-1:0]]) begin
        any = 1'b1;
        idx = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/ctrl_cmd_arbiter.sv
// ctrl_cmd_arbiter: round-robin sharing of the single controller command
// port among NUM_REQ requesters; one command in flight, ownership held
// until the controller drops Busy.
//   Clk, ResetN            clock, async active-low reset
//   Enable                 global enable, mirrored on Cmd.Active
//   ReqValid/ReqRW/ReqMode per-requester request, RW and Mode
//   Grant/Done/Error       per-requester ownership, completion, abort pulse
//   Owner                  index of current/last owner (zero-extended)
//   Cmd                    command port to the RW control FSM
//
// state      | meaning
// StIdle     | no owner; pick next requester when enabled
// StIssue    | ValidCmd high, waiting for Busy (bounded by TIMEOUT)
// StWaitDone | controller busy; wait for Busy to fall
// StComplete | one-cycle Done pulse to owner
// StAbort    | one-cycle Error pulse to owner
module ctrl_cmd_arbiter
  import ctrl_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               Enable,
  input  logic [NUM_REQ-1:0] ReqValid,
  input  logic [NUM_REQ-1:0] ReqRW,
  input  logic [NUM_REQ-1:0] ReqMode,
  output logic [NUM_REQ-1:0] Grant,
  output logic [NUM_REQ-1:0] Done,
  output logic [NUM_REQ-1:0] Error,
  output logic [2:0]         Owner,
  ctrl_cmd_if.master         Cmd
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arbState_t     state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ownerIdx;
  logic [IW-1:0] nextPtr;
  logic [CW-1:0] count;
  logic          validCmd;
  logic          rwLat;
  logic          modeLat;
  logic          pickAny;
  logic [IW-1:0] pickIdx;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) uPick (
    .req (ReqValid),
    .ptr (ptr),
    .any (pickAny),
    .idx (pickIdx)
  );

  assign nextPtr      = (ownerIdx == IW'(NUM_REQ - 1)) ? '0 : ownerIdx + IW'(1);
  assign Owner        = 3'(ownerIdx);
  assign Cmd.ValidCmd = validCmd;
  assign Cmd.RW       = rwLat;
  assign Cmd.Mode     = modeLat;
  assign Cmd.Active   = Enable;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state    <= StIdle;
      ptr      <= '0;
      ownerIdx <= '0;
      count    <= '0;
      validCmd <= 1'b0;
      rwLat    <= RW_READ;
      modeLat  <= MODE_SERIAL;
      Grant    <= '0;
      Done     <= '0;
      Error    <= '0;
    end else begin
      Done  <= '0;
      Error <= '0;
      case (state)
        StIdle: begin
          if (Enable && pickAny) begin
            ownerIdx <= pickIdx;
            rwLat    <= ReqRW[pickIdx];
            modeLat  <= ReqMode[pickIdx];
            Grant    <= ONE << pickIdx;
            validCmd <= 1'b1;
            count    <= '0;
            state    <= StIssue;
          end
        end
        StIssue: begin
          if (count != {CW{1'b1}}) count <= count + CW'(1);
          // Busy has priority over both timeout and Enable loss.
          if (Cmd.Busy) begin
            validCmd <= 1'b0;
            state    <= StWaitDone;
          end else if (!Enable || count == CW'(TIMEOUT - 1)) begin
            validCmd <= 1'b0;
            Grant    <= '0;
            Error    <= ONE << ownerIdx;
            ptr      <= nextPtr;
            state    <= StAbort;
          end
        end
        StWaitDone: begin
          if (!Cmd.Busy) begin
            Grant <= '0;
            Done  <= ONE << ownerIdx;
            ptr   <= nextPtr;
            state <= StComplete;
          end
        end
        StComplete, StAbort: state <= StIdle;
        default:             state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_cmd_arbiter.sv
module tb_ctrl_cmd_arbiter;
  import ctrl_arb_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic         Clk = 1'b0;
  logic         ResetN = 1'b0;
  logic         Enable = 1'b0;
  logic [N-1:0] ReqValid = '0;
  logic [N-1:0] ReqRW = '0;
  logic [N-1:0] ReqMode = '0;
  logic [N-1:0] Grant, Done, Error;
  logic [2:0]   Owner;

  ctrl_cmd_if cmdIf ();

  ctrl_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .Enable   (Enable),
    .ReqValid (ReqValid),
    .ReqRW    (ReqRW),
    .ReqMode  (ReqMode),
    .Grant    (Grant),
    .Done     (Done),
    .Error    (Error),
    .Owner    (Owner),
    .Cmd      (cmdIf)
  );

  always #5 Clk = ~Clk;

  int nTests = 0;
  int nFail  = 0;
  int modelPtr = 0;

  // Per-operation observations filled by run_op.
  int           oVc;
  logic [N-1:0] oGrant, oGrantEnd, oDone, oErr;
  logic [2:0]   oOwner;
  logic         oRw, oMode;
  bit           oRwChanged, oTimedOut;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Reference: first requester at or after ptr, wrapping.
  function automatic int exp_pick(input int ptr, input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Reference: issue cycles seen with ValidCmd high, and whether it ends well.
  function automatic int exp_vc(input int busyDelay, input int enDrop);
    int endK;
    endK = TO - 1;
    if (busyDelay >= 0 && busyDelay < endK) endK = busyDelay;
    if (enDrop >= 0 && enDrop < endK) endK = enDrop;
    return endK + 1;
  endfunction

  function automatic bit exp_ok(input int busyDelay, input int enDrop);
    return busyDelay >= 0 && busyDelay < exp_vc(busyDelay, enDrop);
  endfunction

  task automatic do_reset();
    ResetN = 1'b0;
    ReqValid = '0;
    cmdIf.Busy = 1'b0;
    repeat (2) @(posedge Clk);
    #2 ResetN = 1'b1;
    step();
    modelPtr = 0;
  endtask

  // Plays the controller: Busy rises at issue cycle busyDelay (-1 never)
  // for busyLen cycles; optional Enable drop and ReqRW flip during WAIT.
  task automatic run_op(input int busyDelay, input int busyLen, input int enDrop,
                        input bit toggleRw);
    int w;
    oVc = 0; oGrant = '0; oGrantEnd = '0; oDone = '0; oErr = '0;
    oOwner = '0; oRw = 1'b0; oMode = 1'b0; oRwChanged = 1'b0; oTimedOut = 1'b0;
    w = 0;
    while (!cmdIf.ValidCmd && w < 10) begin
      step();
      w++;
    end
    if (!cmdIf.ValidCmd) begin
      oTimedOut = 1'b1;
      return;
    end
    oGrant = Grant; oOwner = Owner; oRw = cmdIf.RW; oMode = cmdIf.Mode;
    for (int k = 0; k < 80; k++) begin
      if (k == busyDelay) cmdIf.Busy = 1'b1;
      if (busyDelay >= 0 && k == busyDelay + busyLen) cmdIf.Busy = 1'b0;
      if (k == enDrop) Enable = 1'b0;
      if (toggleRw && busyDelay >= 0 && k == busyDelay + 1) ReqRW = ~ReqRW;
      if (cmdIf.RW !== oRw) oRwChanged = 1'b1;
      oVc += int'(cmdIf.ValidCmd);
      oDone |= Done;
      oErr  |= Error;
      if (Done != '0 || Error != '0) begin
        oGrantEnd = Grant;
        cmdIf.Busy = 1'b0;
        Enable = 1'b1;
        return;
      end
      step();
    end
    oTimedOut = 1'b1;
    cmdIf.Busy = 1'b0;
    Enable = 1'b1;
  endtask

  task automatic test_reset();
    logic [N-1:0] oh;
    do_reset();
    nTests++;
    if ({Grant, Done, Error, Owner, cmdIf.ValidCmd, cmdIf.RW, cmdIf.Mode} !== '0) begin
      nFail++;
      $display("FAIL reset_outputs: got G=%b D=%b E=%b O=%0d V=%b RW=%b M=%b, want all 0",
               Grant, Done, Error, Owner, cmdIf.ValidCmd, cmdIf.RW, cmdIf.Mode);
    end
    Enable = 1'b1;
    #1;
    nTests++;
    if (cmdIf.Active !== 1'b1) begin
      nFail++;
      $display("FAIL active_follows: got %b want 1", cmdIf.Active);
    end
    // Advance Ptr to 1, then start requester 1 and reset during ISSUE.
    ReqValid = 4'b0001;
    run_op(0, 1, -1, 1'b0);
    ReqValid = 4'b0010;
    step();
    step();
    nTests++;
    if (cmdIf.ValidCmd !== 1'b1 || Grant !== 4'b0010) begin
      nFail++;
      $display("FAIL reset_pre_issue: got V=%b G=%b want V=1 G=0010", cmdIf.ValidCmd, Grant);
    end
    #2 ResetN = 1'b0;
    #1;
    nTests++;
    if ({Grant, Done, Error, Owner, cmdIf.ValidCmd, cmdIf.RW, cmdIf.Mode} !== '0) begin
      nFail++;
      $display("FAIL reset_mid_issue: got G=%b O=%0d V=%b, want all 0",
               Grant, Owner, cmdIf.ValidCmd);
    end
    #8 ResetN = 1'b1;
    ReqValid = 4'b1111;
    step();
    modelPtr = 0;
    run_op(0, 1, -1, 1'b0);
    oh = 4'b0001;
    nTests++;
    if (oTimedOut || oGrant !== oh || oDone !== oh) begin
      nFail++;
      $display("FAIL reset_ptr_zero: got G=%b D=%b to=%0d want G=%b D=%b",
               oGrant, oDone, oTimedOut, oh, oh);
    end
    modelPtr = 1;
    ReqValid = '0;
    step();
  endtask

  task automatic test_single();
    ReqValid = 4'b0001; ReqRW = {N{RW_READ}}; ReqMode = {N{MODE_MEM}};
    run_op(1, 5, -1, 1'b0);
    ReqValid = '0;
    nTests++;
    if (oTimedOut || oVc != 2 || oGrant !== 4'b0001 || oDone !== 4'b0001 || oErr !== '0) begin
      nFail++;
      $display("FAIL single_op: got vc=%0d G=%b D=%b E=%b to=%0d want vc=2 G=0001 D=0001 E=0000",
               oVc, oGrant, oDone, oErr, oTimedOut);
    end
    nTests++;
    if (oRw !== RW_READ || oMode !== MODE_MEM || oOwner !== 3'd0 || oGrantEnd !== '0) begin
      nFail++;
      $display("FAIL single_fields: got RW=%b M=%b O=%0d Gend=%b want 0 1 0 0000",
               oRw, oMode, oOwner, oGrantEnd);
    end
    step();
    nTests++;
    if (Done !== '0 || Error !== '0) begin
      nFail++;
      $display("FAIL done_once: got D=%b E=%b want 0000 0000", Done, Error);
    end
    // Ptr is now 1: with requesters 0 and 3 waiting, 3 comes first.
    ReqValid = 4'b1001;
    run_op(0, 1, -1, 1'b0);
    ReqValid = '0;
    nTests++;
    if (oGrant !== 4'b1000) begin
      nFail++;
      $display("FAIL single_ptr1: got G=%b want 1000", oGrant);
    end
    modelPtr = 0;
    step();
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    Enable = 1'b1;
    ReqValid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), -1, 1'b0);
      nTests++;
      if (oTimedOut || oOwner !== 3'(order[i]) || oDone !== (4'b0001 << order[i])) begin
        nFail++;
        $display("FAIL rr_order[%0d]: got O=%0d D=%b want O=%0d D=%b",
                 i, oOwner, oDone, order[i], 4'b0001 << order[i]);
      end
    end
    ReqValid = '0;
    modelPtr = 1;
    step();
  endtask

  task automatic test_timeout();
    ReqValid = 4'b0100;
    run_op(-1, 1, -1, 1'b0);
    ReqValid = '0;
    nTests++;
    if (oTimedOut || oVc != TO || oErr !== 4'b0100 || oDone !== '0) begin
      nFail++;
      $display("FAIL timeout: got vc=%0d E=%b D=%b want vc=%0d E=0100 D=0000",
               oVc, oErr, oDone, TO);
    end
    step();
    ReqValid = 4'b1111;
    run_op(0, 1, -1, 1'b0);
    ReqValid = '0;
    nTests++;
    if (oGrant !== 4'b1000) begin
      nFail++;
      $display("FAIL timeout_next_ptr: got G=%b want 1000", oGrant);
    end
    modelPtr = 0;
    step();
  endtask

  task automatic test_enable();
    ReqValid = 4'b0010;
    run_op(-1, 1, 3, 1'b0);
    ReqValid = '0;
    nTests++;
    if (oTimedOut || oVc != 4 || oErr !== 4'b0010 || oDone !== '0) begin
      nFail++;
      $display("FAIL enable_issue: got vc=%0d E=%b D=%b want vc=4 E=0010 D=0000",
               oVc, oErr, oDone);
    end
    step();
    ReqValid = 4'b0010;
    run_op(1, 4, 3, 1'b0);
    ReqValid = '0;
    nTests++;
    if (oTimedOut || oDone !== 4'b0010 || oErr !== '0) begin
      nFail++;
      $display("FAIL enable_wait: got D=%b E=%b want D=0010 E=0000", oDone, oErr);
    end
    modelPtr = 2;
    step();
  endtask

  task automatic test_rw_stable();
    ReqValid = 4'b0100; ReqRW = {N{RW_WRITE}};
    run_op(0, 4, -1, 1'b1);
    ReqValid = '0;
    nTests++;
    if (oTimedOut || oRw !== RW_WRITE || oRwChanged) begin
      nFail++;
      $display("FAIL rw_stable: got RW=%b changed=%0d want RW=1 changed=0", oRw, oRwChanged);
    end
    step();
    ReqValid = 4'b1000;
    run_op(TO - 1, 2, -1, 1'b0);
    ReqValid = '0;
    nTests++;
    if (oTimedOut || oVc != TO || oDone !== 4'b1000 || oErr !== '0) begin
      nFail++;
      $display("FAIL busy_at_timeout: got vc=%0d D=%b E=%b want vc=%0d D=1000 E=0000",
               oVc, oDone, oErr, TO);
    end
    modelPtr = 0;
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] mask, ohx;
    int idx, bd, ed, evc;
    bit ok;
    for (int it = 0; it < 25; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      ReqRW = N'($urandom);
      ReqMode = N'($urandom);
      bd = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO + 1));
      ed = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, TO)) : -1;
      idx = exp_pick(modelPtr, mask);
      ohx = 4'b0001 << idx;
      evc = exp_vc(bd, ed);
      ok = exp_ok(bd, ed);
      ReqValid = mask;
      run_op(bd, int'($urandom_range(1, 4)), ed, 1'b0);
      ReqValid = '0;
      nTests++;
      if (oTimedOut || oGrant !== ohx || oOwner !== 3'(idx) || oRw !== ReqRW[idx] ||
          oMode !== ReqMode[idx]) begin
        nFail++;
        $display("FAIL rand_pick[%0d]: got G=%b O=%0d RW=%b M=%b want G=%b O=%0d RW=%b M=%b",
                 it, oGrant, oOwner, oRw, oMode, ohx, idx, ReqRW[idx], ReqMode[idx]);
      end
      nTests++;
      if (oVc != evc || oDone !== (ok ? ohx : 4'b0000) || oErr !== (ok ? 4'b0000 : ohx)) begin
        nFail++;
        $display("FAIL rand_result[%0d]: got vc=%0d D=%b E=%b want vc=%0d D=%b E=%b",
                 it, oVc, oDone, oErr, evc, ok ? ohx : 4'b0000, ok ? 4'b0000 : ohx);
      end
      modelPtr = (idx + 1) % N;
      step();
      nTests++;
      if (Grant !== '0 || Done !== '0 || Error !== '0 || cmdIf.Active !== Enable) begin
        nFail++;
        $display("FAIL rand_idle[%0d]: got G=%b D=%b E=%b A=%b want 0 0 0 %b",
                 it, Grant, Done, Error, cmdIf.Active, Enable);
      end
    end
  endtask

  initial begin
    cmdIf.Busy = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_enable();
    test_rw_stable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want completion");
    $fatal(1, "global timeout");
  end

endmodule
